// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP controller state encodings and default data-register
// geometry used by the TAP-side registers.
package jtag_pkg;

   // IEEE 1149.1 TAP controller state encodings
   typedef enum logic [3:0] {
      TapExit2Dr        = 4'h0,
      TapExit1Dr        = 4'h1,
      TapShiftDr        = 4'h2,
      TapPauseDr        = 4'h3,
      TapSelectIrScan   = 4'h4,
      TapUpdateDr       = 4'h5,
      TapCaptureDr      = 4'h6,
      TapSelectDrScan   = 4'h7,
      TapExit2Ir        = 4'h8,
      TapExit1Ir        = 4'h9,
      TapShiftIr        = 4'hA,
      TapPauseIr        = 4'hB,
      TapRunTestIdle    = 4'hC,
      TapUpdateIr       = 4'hD,
      TapCaptureIr      = 4'hE,
      TapTestLogicReset = 4'hF
   } tap_state_e;

   localparam int unsigned DefaultBits       = 32;
   localparam logic [63:0] DefaultResetValue = 64'h0000_0000_1234_5678;

endpackage

// File: rtl/clock_gater.sv
// Glitch-free clock gate: enable is captured by a latch that is transparent while the
// clock is low, so the gated clock never produces truncated pulses.
module clock_gater (
   input  logic clk_in,
   input  logic enable,
   input  logic atg_clk_mode,
   output logic clk_out
);

   logic en_latched;

   // No reset: the first low phase of clk_in defines the latch contents.
   always_latch begin
      if (!clk_in) begin
         en_latched <= enable;
      end
   end

   assign clk_out = clk_in & (en_latched | atg_clk_mode);

endmodule

// File: rtl/jtag_rpc_in_reg.sv
// JTAG data register with parallel capture and LSB-first shift, plus a gated clock
// that runs only while the register is being captured or shifted.
module jtag_rpc_in_reg
   import jtag_pkg::*;
#(
   parameter int unsigned BITS        = DefaultBits,
   parameter logic [63:0] RESET_VALUE = DefaultResetValue
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            select,
   input  logic            capture_dr,
   input  logic            shift_dr,
   input  logic [BITS-1:0] capture_value,
   input  logic            tdi,
   input  logic            atg_clk_mode,
   output logic            tdo,
   output logic            shiftcapture_clk_o,
   output logic [BITS-1:0] data_o
);

   logic [BITS-1:0] sr_q, sr_d, sr_shift;
   logic            gate_en;

   // tdi enters at the MSB; a one-bit register simply loads tdi.
   if (BITS == 1) begin : g_shift_one
      assign sr_shift = tdi;
   end else begin : g_shift_wide
      assign sr_shift = {tdi, sr_q[BITS-1:1]};
   end

   always_comb begin
      sr_d = sr_q;
      if (select && capture_dr) begin
         sr_d = capture_value;
      end else if (select && shift_dr) begin
         sr_d = sr_shift;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q <= RESET_VALUE[BITS-1:0];
      end else begin
         sr_q <= sr_d;
      end
   end

   assign data_o  = sr_q;
   assign tdo     = sr_q[0];
   assign gate_en = select & (capture_dr | shift_dr);

   clock_gater u_clock_gater (
      .clk_in       (clk),
      .enable       (gate_en),
      .atg_clk_mode (atg_clk_mode),
      .clk_out      (shiftcapture_clk_o)
   );

endmodule

// File: tb/tb_jtag_rpc_in_reg.sv
// Directed bench for jtag_rpc_in_reg: a 32-bit default instance plus a 1-bit instance.
module tb_jtag_rpc_in_reg;

   logic        clk = 1'b0;
   logic        reset, select, capture_dr, shift_dr, tdi, atg_clk_mode;
   logic [31:0] capture_value;
   logic        tdo, gclk;
   logic [31:0] data;
   logic        tdo1, gclk1;
   logic [0:0]  data1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   jtag_rpc_in_reg dut (
      .clk                (clk),
      .reset              (reset),
      .select             (select),
      .capture_dr         (capture_dr),
      .shift_dr           (shift_dr),
      .capture_value      (capture_value),
      .tdi                (tdi),
      .atg_clk_mode       (atg_clk_mode),
      .tdo                (tdo),
      .shiftcapture_clk_o (gclk),
      .data_o             (data)
   );

   jtag_rpc_in_reg #(
      .BITS        (1),
      .RESET_VALUE (64'h3)
   ) dut1 (
      .clk                (clk),
      .reset              (reset),
      .select             (select),
      .capture_dr         (capture_dr),
      .shift_dr           (shift_dr),
      .capture_value      (capture_value[0:0]),
      .tdi                (tdi),
      .atg_clk_mode       (atg_clk_mode),
      .tdo                (tdo1),
      .shiftcapture_clk_o (gclk1),
      .data_o             (data1)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge (clk is high here).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_sr;

   initial begin
      reset = 1'b1; select = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0;
      tdi = 1'b0; atg_clk_mode = 1'b0; capture_value = '0;

      // Reset
      step();
      check_eq("reset_data", 64'(data), 64'h1234_5678);
      check_eq("reset_tdo", 64'(tdo), 64'h0);
      check_eq("reset_gclk_idle", 64'(gclk), 64'h0);
      check_eq("reset_data_b1", 64'(data1), 64'h1);

      // Capture
      reset = 1'b0; select = 1'b1; capture_dr = 1'b1; capture_value = 32'hA5A5_0F0F;
      step();
      check_eq("capture_data", 64'(data), 64'hA5A5_0F0F);
      check_eq("capture_tdo", 64'(tdo), 64'h1);
      check_eq("capture_gclk", 64'(gclk), 64'h1);
      check_eq("capture_b1", 64'(data1), 64'h1);

      // Shift 32 ones in; tdo walks the captured value LSB first
      capture_dr = 1'b0; shift_dr = 1'b1; tdi = 1'b1;
      exp_sr = 32'hA5A5_0F0F;
      for (int i = 0; i < 32; i++) begin
         step();
         exp_sr = {1'b1, exp_sr[31:1]};
         check_eq($sformatf("shift_tdo_%0d", i), 64'(tdo), 64'(exp_sr[0]));
      end
      check_eq("shift_final", 64'(data), 64'hFFFF_FFFF);
      check_eq("shift_gclk", 64'(gclk), 64'h1);

      // Deselected: hold, gated clock stays low
      select = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check_eq($sformatf("desel_gclk_%0d", i), 64'(gclk), 64'h0);
      end
      check_eq("desel_data", 64'(data), 64'hFFFF_FFFF);

      // Capture beats shift
      select = 1'b1; capture_dr = 1'b1; shift_dr = 1'b1; capture_value = 32'h1;
      step();
      check_eq("priority_data", 64'(data), 64'h1);

      // Reset mid-shift
      capture_dr = 1'b1; shift_dr = 1'b0; capture_value = 32'hDEAD_BEEF;
      step();
      capture_dr = 1'b0; shift_dr = 1'b1; tdi = 1'b0;
      repeat (5) step();
      check_eq("midshift_data", 64'(data), 64'h06F5_6DF7);
      check_eq("midshift_b1", 64'(data1), 64'h0);
      reset = 1'b1;
      step();
      check_eq("midshift_reset", 64'(data), 64'h1234_5678);
      check_eq("midshift_reset_tdo", 64'(tdo), 64'h0);
      check_eq("reset_gclk_enabled", 64'(gclk), 64'h1);
      reset = 1'b0;

      // Enable dropped while clk is high: pulse must not be truncated
      step();
      check_eq("glitch_on_before", 64'(gclk), 64'h1);
      select = 1'b0;
      #2;
      check_eq("glitch_on_after", 64'(gclk), 64'h1);
      // Enable raised while clk is high: no early pulse
      step();
      check_eq("glitch_off_before", 64'(gclk), 64'h0);
      select = 1'b1;
      #2;
      check_eq("glitch_off_after", 64'(gclk), 64'h0);
      step();
      check_eq("glitch_next_edge", 64'(gclk), 64'h1);

      // Test-mode override with enable low
      select = 1'b0; atg_clk_mode = 1'b1;
      step();
      check_eq("atg_high", 64'(gclk), 64'h1);
      @(negedge clk);
      #1;
      check_eq("atg_low", 64'(gclk), 64'h0);
      atg_clk_mode = 1'b0;
      step();
      check_eq("atg_off", 64'(gclk), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
